// File: rtl/rank_pipe_pkg.sv
// rank_pipe_pkg: shared definitions for the rank pipe.
//  - Default widths for rank, metadata and flow ID.
//  - rank_entry_t: one output-FIFO entry {rank, meta, flow_id}.
//  - mod_gt / mod_max: wrap-aware rank comparisons. They are correct while all
//    live ranks lie within half the rank space of each other.
package rank_pipe_pkg;

  localparam int RANK_WIDTH_DEF    = 16;
  localparam int META_WIDTH_DEF    = 16;
  localparam int FLOW_ID_WIDTH_DEF = 16;

  typedef struct packed {
    logic [RANK_WIDTH_DEF-1:0]    rank;
    logic [META_WIDTH_DEF-1:0]    meta;
    logic [FLOW_ID_WIDTH_DEF-1:0] flow_id;
  } rank_entry_t;

  // a is "after" b when the wrapped difference is nonzero and in the lower half.
  function automatic logic mod_gt(input logic [RANK_WIDTH_DEF-1:0] a,
                                  input logic [RANK_WIDTH_DEF-1:0] b);
    logic [RANK_WIDTH_DEF-1:0] diff;
    diff = a - b;
    return (diff != {RANK_WIDTH_DEF{1'b0}}) && (diff[RANK_WIDTH_DEF-1] == 1'b0);
  endfunction

  function automatic logic [RANK_WIDTH_DEF-1:0] mod_max(input logic [RANK_WIDTH_DEF-1:0] a,
                                                         input logic [RANK_WIDTH_DEF-1:0] b);
    return mod_gt(a, b) ? a : b;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: small synchronous FIFO whose head is visible on dout
// in the cycle after it is written (no read latency).
// Ports:
//  clk, reset     clock, asynchronous active-high reset (empties the FIFO)
//  din, wr_en     write data / strobe (ignored while full)
//  rd_en          pop head (ignored while empty)
//  dout           head entry, valid while empty = 0
//  full           2**MAX_DEPTH_BITS entries held
//  nearly_full    at least 2**MAX_DEPTH_BITS - 1 entries held
//  empty          no entries held
// Status flags are flops computed from the next occupancy.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 48,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   depth_q, depth_d;
  logic                      empty_q, empty_d;
  logic                      full_q, full_d;
  logic                      nf_q, nf_d;
  logic                      do_wr_s, do_rd_s;

  // Next pointers, occupancy and flags.
  always_comb begin
    do_wr_s  = wr_en && !full_q;
    do_rd_s  = rd_en && !empty_q;
    wr_ptr_d = do_wr_s ? (wr_ptr_q + MAX_DEPTH_BITS'(1)) : wr_ptr_q;
    rd_ptr_d = do_rd_s ? (rd_ptr_q + MAX_DEPTH_BITS'(1)) : rd_ptr_q;
    case ({do_wr_s, do_rd_s})
      2'b10:   depth_d = depth_q + (MAX_DEPTH_BITS+1)'(1);
      2'b01:   depth_d = depth_q - (MAX_DEPTH_BITS+1)'(1);
      default: depth_d = depth_q;
    endcase
    empty_d = (depth_d == (MAX_DEPTH_BITS+1)'(0));
    full_d  = (depth_d == (MAX_DEPTH_BITS+1)'(DEPTH));
    nf_d    = (depth_d >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {MAX_DEPTH_BITS{1'b0}};
      rd_ptr_q <= {MAX_DEPTH_BITS{1'b0}};
      depth_q  <= {(MAX_DEPTH_BITS+1){1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      nf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      depth_q  <= depth_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      nf_q     <= nf_d;
    end
  end

  // Storage array; contents are meaningless while empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout        = mem_q[rd_ptr_q];
  assign full        = full_q;
  assign nearly_full = nf_q;
  assign empty       = empty_q;

endmodule

// File: rtl/stride_rank.sv
// stride_rank: rank computation stage of the rank pipe.
//  rank = max(flow_last_rank, vtime) + stride, wrapping modulo 2**RANK_WIDTH.
//  A flow with no packets outstanding restarts from vtime, so idle flows
//  cannot bank credit. {rank, meta, flowID} is queued in an output FIFO.
// Ports:
//  clk, rst                     clock, asynchronous active-high reset
//  busy                         FIFO nearly full or a flow counter saturated
//  insert, flowID_in, meta_in   packet insert
//  remove                       pop the head (ignored when valid_out = 0)
//  valid_out, rank_out,
//  meta_out, flowID_out         FIFO head (fall-through)
//  flow_err                     one-cycle pulse after an out-of-range insert
//  cfg_wr, cfg_flow, cfg_stride per-flow stride write (only with STRIDE_CFG_EN)
// Build option: define STRIDE_CFG_EN for programmable strides; otherwise
// every flow has stride 1 (pure round-robin).
// Width parameters must match the rank_pipe_pkg defaults (rank_entry_t).
module stride_rank
  import rank_pipe_pkg::*;
#(
  parameter int FLOW_ID_WIDTH = FLOW_ID_WIDTH_DEF,
  parameter int MAX_NUM_FLOWS = 8,
  parameter int RANK_WIDTH    = RANK_WIDTH_DEF,
  parameter int META_WIDTH    = META_WIDTH_DEF,
  parameter int STRIDE_WIDTH  = 8,
  parameter int L2_FIFO_DEPTH = 4,
  parameter int PKT_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  input  logic                     insert,
  input  logic [FLOW_ID_WIDTH-1:0] flowID_in,
  input  logic [META_WIDTH-1:0]    meta_in,
  input  logic                     remove,
  output logic                     valid_out,
  output logic [RANK_WIDTH-1:0]    rank_out,
  output logic [META_WIDTH-1:0]    meta_out,
  output logic [FLOW_ID_WIDTH-1:0] flowID_out,
`ifdef STRIDE_CFG_EN
  output logic                     flow_err,
  input  logic                     cfg_wr,
  input  logic [FLOW_ID_WIDTH-1:0] cfg_flow,
  input  logic [STRIDE_WIDTH-1:0]  cfg_stride
`else
  output logic                     flow_err
`endif
);

  localparam int IDX_W = (MAX_NUM_FLOWS > 1) ? $clog2(MAX_NUM_FLOWS) : 1;

  logic [RANK_WIDTH-1:0]    last_rank_q [MAX_NUM_FLOWS];
  logic [RANK_WIDTH-1:0]    last_rank_d [MAX_NUM_FLOWS];
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q   [MAX_NUM_FLOWS];
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt_d   [MAX_NUM_FLOWS];
  logic [RANK_WIDTH-1:0]    vtime_q, vtime_d;
  logic                     flow_err_q, flow_err_d;
  logic                     cnt_max_q, cnt_max_d;

  logic [IDX_W-1:0]         ins_idx_s, rem_idx_s;
  logic                     legal_s, do_ins_s, do_rem_s;
  logic [STRIDE_WIDTH-1:0]  ins_stride_s;
  logic [RANK_WIDTH-1:0]    base_s, rank_s;
  rank_entry_t              wr_entry_s, head_entry_s;
  logic                     fifo_empty_s, fifo_full_s, fifo_nf_s;

  assign ins_idx_s = flowID_in[IDX_W-1:0];
  assign legal_s   = (flowID_in < FLOW_ID_WIDTH'(MAX_NUM_FLOWS));
  assign do_ins_s  = insert && legal_s;
  assign do_rem_s  = remove && !fifo_empty_s;
  assign rem_idx_s = head_entry_s.flow_id[IDX_W-1:0];

`ifdef STRIDE_CFG_EN
  logic [STRIDE_WIDTH-1:0] stride_q [MAX_NUM_FLOWS];
  logic [STRIDE_WIDTH-1:0] stride_d [MAX_NUM_FLOWS];
  logic [IDX_W-1:0]        cfg_idx_s;

  assign cfg_idx_s    = cfg_flow[IDX_W-1:0];
  // The insert reads the pre-edge stride, so a coincident write takes effect next cycle.
  assign ins_stride_s = stride_q[ins_idx_s];

  // Stride table update; a zero stride is coerced to 1 so ranks always advance.
  always_comb begin
    stride_d = stride_q;
    if (cfg_wr && (cfg_flow < FLOW_ID_WIDTH'(MAX_NUM_FLOWS))) begin
      stride_d[cfg_idx_s] = (cfg_stride == {STRIDE_WIDTH{1'b0}}) ? STRIDE_WIDTH'(1) : cfg_stride;
    end else begin
      stride_d[cfg_idx_s] = stride_q[cfg_idx_s];
    end
  end

  // Stride table registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_NUM_FLOWS; i++) stride_q[i] <= STRIDE_WIDTH'(1);
    end else begin
      stride_q <= stride_d;
    end
  end
`else
  assign ins_stride_s = STRIDE_WIDTH'(1);
`endif

  // Rank of the inserted packet from pre-edge state; an active flow (even one
  // being popped this cycle) continues from its own last rank.
  always_comb begin
    if (pkt_cnt_q[ins_idx_s] == {PKT_CNT_WIDTH{1'b0}}) begin
      base_s = vtime_q;
    end else begin
      base_s = mod_max(last_rank_q[ins_idx_s], vtime_q);
    end
    rank_s = base_s + RANK_WIDTH'(ins_stride_s);
  end

  // Flow table, virtual time and status next-state.
  always_comb begin
    last_rank_d = last_rank_q;
    pkt_cnt_d   = pkt_cnt_q;
    if (do_rem_s) begin
      pkt_cnt_d[rem_idx_s] = pkt_cnt_q[rem_idx_s] - PKT_CNT_WIDTH'(1);
      vtime_d              = head_entry_s.rank;
    end else begin
      vtime_d = vtime_q;
    end
    // Applied after the decrement so a same-flow insert+remove nets to zero.
    if (do_ins_s) begin
      last_rank_d[ins_idx_s] = rank_s;
      pkt_cnt_d[ins_idx_s]   = pkt_cnt_d[ins_idx_s] + PKT_CNT_WIDTH'(1);
    end else begin
      last_rank_d[ins_idx_s] = last_rank_q[ins_idx_s];
    end
    flow_err_d = insert && !legal_s;
    cnt_max_d  = 1'b0;
    for (int i = 0; i < MAX_NUM_FLOWS; i++) begin
      cnt_max_d = cnt_max_d | (pkt_cnt_d[i] == {PKT_CNT_WIDTH{1'b1}});
    end
  end

  // Flow table, virtual time and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_NUM_FLOWS; i++) begin
        last_rank_q[i] <= {RANK_WIDTH{1'b0}};
        pkt_cnt_q[i]   <= {PKT_CNT_WIDTH{1'b0}};
      end
      vtime_q    <= {RANK_WIDTH{1'b0}};
      flow_err_q <= 1'b0;
      cnt_max_q  <= 1'b0;
    end else begin
      last_rank_q <= last_rank_d;
      pkt_cnt_q   <= pkt_cnt_d;
      vtime_q     <= vtime_d;
      flow_err_q  <= flow_err_d;
      cnt_max_q   <= cnt_max_d;
    end
  end

  assign wr_entry_s = '{rank: rank_s, meta: meta_in, flow_id: flowID_in};

  fallthrough_small_fifo #(
    .WIDTH          (RANK_WIDTH + META_WIDTH + FLOW_ID_WIDTH),
    .MAX_DEPTH_BITS (L2_FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (rst),
    .din         (wr_entry_s),
    .wr_en       (do_ins_s),
    .rd_en       (remove),
    .dout        (head_entry_s),
    .full        (fifo_full_s),
    .nearly_full (fifo_nf_s),
    .empty       (fifo_empty_s)
  );

  assign valid_out  = !fifo_empty_s;
  assign rank_out   = head_entry_s.rank;
  assign meta_out   = head_entry_s.meta;
  assign flowID_out = head_entry_s.flow_id;
  assign busy       = fifo_nf_s | fifo_full_s | cnt_max_q;
  assign flow_err   = flow_err_q;

endmodule

// File: tb/tb_stride_rank.sv
module tb_stride_rank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        insert = 1'b0;
  logic [15:0] flowID_in = 16'd0;
  logic [15:0] meta_in = 16'd0;
  logic        remove = 1'b0;
  logic        busy, valid_out, flow_err;
  logic [15:0] rank_out, meta_out, flowID_out;
`ifdef STRIDE_CFG_EN
  logic        cfg_wr = 1'b0;
  logic [15:0] cfg_flow = 16'd0;
  logic [7:0]  cfg_stride = 8'd0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stride_rank dut (
    .clk(clk), .rst(rst), .busy(busy), .insert(insert), .flowID_in(flowID_in),
    .meta_in(meta_in), .remove(remove), .valid_out(valid_out), .rank_out(rank_out),
    .meta_out(meta_out), .flowID_out(flowID_out),
`ifdef STRIDE_CFG_EN
    .flow_err(flow_err), .cfg_wr(cfg_wr), .cfg_flow(cfg_flow), .cfg_stride(cfg_stride)
`else
    .flow_err(flow_err)
`endif
  );

  // Inserting while busy is illegal; the bench must never do it.
  always @(posedge clk) begin
    if (!rst) assert (!(insert && busy)) else $error("FAIL insert_while_busy");
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // One clock with the given insert/remove; outputs are sampled 1 time unit after the edge.
  task automatic op(input logic ins, input logic [15:0] fid, input logic rem);
    insert = ins; flowID_in = fid; meta_in = fid ^ 16'h5A00; remove = rem;
    @(posedge clk); #1;
    insert = 1'b0; remove = 1'b0;
  endtask

`ifdef STRIDE_CFG_EN
  task automatic cfg_op(input logic ins, input logic [15:0] fid,
                        input logic [15:0] cflow, input logic [7:0] cstr);
    cfg_wr = 1'b1; cfg_flow = cflow; cfg_stride = cstr;
    insert = ins; flowID_in = fid; meta_in = fid ^ 16'h5A00;
    @(posedge clk); #1;
    cfg_wr = 1'b0; insert = 1'b0;
  endtask
`endif

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({valid_out, busy, flow_err} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got v/b/e=%b exp 000", {valid_out, busy, flow_err});
    end
  endtask

  // Three flows, two rounds at stride 1: ranks 1,1,1 then 2,2,2 in insert order.
  task automatic test_round_robin();
    logic [15:0] exp_rank, exp_flow;
    for (int r = 0; r < 2; r++)
      for (int f = 0; f < 3; f++) op(1'b1, 16'(f), 1'b0);
    for (int k = 0; k < 6; k++) begin
      exp_rank = 16'(k / 3 + 1);
      exp_flow = 16'(k % 3);
      n_cmp++; if ({valid_out, rank_out, flowID_out, meta_out} !== {1'b1, exp_rank, exp_flow, exp_flow ^ 16'h5A00}) begin
        n_err++; $display("FAIL rr_head%0d got v=%b r=%h f=%h m=%h exp r=%h f=%h", k, valid_out, rank_out, flowID_out, meta_out, exp_rank, exp_flow);
      end
      op(1'b0, 16'd0, 1'b1);
    end
    n_cmp++; if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL rr_empty got %b exp 0", valid_out);
    end
  endtask

  // Out-of-range flow IDs are dropped and pulse flow_err for one cycle.
  task automatic test_illegal_flow();
    op(1'b1, 16'd8, 1'b0);
    n_cmp++; if ({flow_err, valid_out} !== 2'b10) begin
      n_err++; $display("FAIL illegal8 got err/v=%b exp 10", {flow_err, valid_out});
    end
    op(1'b0, 16'd0, 1'b0);
    n_cmp++; if ({flow_err, valid_out} !== 2'b00) begin
      n_err++; $display("FAIL illegal_pulse_end got err/v=%b exp 00", {flow_err, valid_out});
    end
    op(1'b1, 16'h0108, 1'b0);
    n_cmp++; if ({flow_err, valid_out} !== 2'b10) begin
      n_err++; $display("FAIL illegal108 got err/v=%b exp 10", {flow_err, valid_out});
    end
    op(1'b0, 16'd0, 1'b0);
  endtask

  // vtime is 2: a drained flow restarts from vtime, not from its own last rank.
  task automatic test_drain_rejoin();
    op(1'b1, 16'd0, 1'b0);
    n_cmp++; if (rank_out !== 16'd3) begin
      n_err++; $display("FAIL drain_f0a got %h exp 0003", rank_out);
    end
    op(1'b0, 16'd0, 1'b1);
    op(1'b1, 16'd0, 1'b0);
    n_cmp++; if (rank_out !== 16'd4) begin
      n_err++; $display("FAIL drain_f0b got %h exp 0004", rank_out);
    end
    op(1'b0, 16'd0, 1'b1);
    op(1'b1, 16'd1, 1'b0);
    n_cmp++; if ({rank_out, flowID_out} !== {16'd5, 16'd1}) begin
      n_err++; $display("FAIL rejoin_f1 got r=%h f=%h exp r=0005 f=0001", rank_out, flowID_out);
    end
  endtask

  // Head is flow1 rank 5 (its only packet), vtime 4. Insert+pop keeps flow1 active.
  task automatic test_simultaneous();
    op(1'b1, 16'd1, 1'b1);
    n_cmp++; if ({valid_out, rank_out, flowID_out} !== {1'b1, 16'd6, 16'd1}) begin
      n_err++; $display("FAIL simul_rank got v=%b r=%h f=%h exp r=0006 f=0001", valid_out, rank_out, flowID_out);
    end
    op(1'b1, 16'd1, 1'b0);
    op(1'b0, 16'd0, 1'b1);
    n_cmp++; if (rank_out !== 16'd7) begin
      n_err++; $display("FAIL simul_next got %h exp 0007", rank_out);
    end
    op(1'b0, 16'd0, 1'b1);
    n_cmp++; if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL simul_empty got %b exp 0", valid_out);
    end
  endtask

  // vtime is 7: back-to-back flow2 inserts give 8..22; busy rises at 15 entries.
  task automatic test_fill_busy();
    for (int i = 0; i < 15; i++) begin
      n_cmp++; if (busy !== 1'b0) begin
        n_err++; $display("FAIL fill_busy_early%0d got %b exp 0", i, busy);
      end
      op(1'b1, 16'd2, 1'b0);
    end
    n_cmp++; if ({busy, valid_out, rank_out} !== {1'b1, 1'b1, 16'd8}) begin
      n_err++; $display("FAIL fill_full got b=%b v=%b r=%h exp b=1 v=1 r=0008", busy, valid_out, rank_out);
    end
    op(1'b0, 16'd0, 1'b1);
    n_cmp++; if ({busy, rank_out} !== {1'b0, 16'd9}) begin
      n_err++; $display("FAIL fill_pop got b=%b r=%h exp b=0 r=0009", busy, rank_out);
    end
    op(1'b1, 16'd2, 1'b1);
    n_cmp++; if ({busy, rank_out} !== {1'b0, 16'd10}) begin
      n_err++; $display("FAIL fill_simul got b=%b r=%h exp b=0 r=000a", busy, rank_out);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rank_out !== 16'(10 + k)) begin
        n_err++; $display("FAIL fill_seq%0d got %h exp %h", k, rank_out, 16'(10 + k));
      end
      op(1'b0, 16'd0, 1'b1);
    end
  endtask

  // Reset asserted mid-cycle with entries queued clears outputs immediately.
  task automatic test_reset_mid();
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if ({valid_out, busy, flow_err} !== 3'b000) begin
      n_err++; $display("FAIL async_rst got v/b/e=%b exp 000", {valid_out, busy, flow_err});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    op(1'b1, 16'd0, 1'b0);
    n_cmp++; if ({valid_out, rank_out} !== {1'b1, 16'd1}) begin
      n_err++; $display("FAIL post_rst got v=%b r=%h exp v=1 r=0001", valid_out, rank_out);
    end
    op(1'b0, 16'd0, 1'b1);
  endtask

`ifdef STRIDE_CFG_EN
  task automatic test_weighted();
    logic [15:0] exp_r [4] = '{16'd1, 16'd2, 16'd3, 16'd3};
    logic [15:0] exp_f [4] = '{16'd0, 16'd0, 16'd0, 16'd1};
    do_reset();
    cfg_op(1'b0, 16'd0, 16'd1, 8'd3);
    op(1'b1, 16'd0, 1'b0); op(1'b1, 16'd0, 1'b0); op(1'b1, 16'd0, 1'b0); op(1'b1, 16'd1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({rank_out, flowID_out} !== {exp_r[k], exp_f[k]}) begin
        n_err++; $display("FAIL weighted%0d got r=%h f=%h exp r=%h f=%h", k, rank_out, flowID_out, exp_r[k], exp_f[k]);
      end
      op(1'b0, 16'd0, 1'b1);
    end
    // vtime 3: coincident write uses the old stride, next insert uses 5.
    cfg_op(1'b1, 16'd0, 16'd0, 8'd5);
    cfg_op(1'b1, 16'd0, 16'd8, 8'd9);
    cfg_op(1'b1, 16'd2, 16'd2, 8'd0);
    op(1'b1, 16'd2, 1'b0);
    exp_r = '{16'd4, 16'd9, 16'd4, 16'd5};
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rank_out !== exp_r[k]) begin
        n_err++; $display("FAIL cfg_rank%0d got %h exp %h", k, rank_out, exp_r[k]);
      end
      op(1'b0, 16'd0, 1'b1);
    end
  endtask

  // Walk vtime to 0xFFFE with stride 217 (302 steps), then wrap with stride 3.
  task automatic test_wrap();
    do_reset();
    cfg_op(1'b0, 16'd0, 16'd0, 8'd217);
    op(1'b1, 16'd0, 1'b0);
    for (int i = 0; i < 301; i++) op(1'b1, 16'd0, 1'b1);
    n_cmp++; if (rank_out !== 16'hFFFE) begin
      n_err++; $display("FAIL wrap_pre got %h exp fffe", rank_out);
    end
    op(1'b0, 16'd0, 1'b1);
    cfg_op(1'b0, 16'd0, 16'd0, 8'd3);
    op(1'b1, 16'd0, 1'b0);
    op(1'b1, 16'd0, 1'b0);
    n_cmp++; if (rank_out !== 16'h0001) begin
      n_err++; $display("FAIL wrap_rank got %h exp 0001", rank_out);
    end
    op(1'b0, 16'd0, 1'b1);
    n_cmp++; if (rank_out !== 16'h0004) begin
      n_err++; $display("FAIL wrap_modmax got %h exp 0004", rank_out);
    end
    op(1'b0, 16'd0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_illegal_flow();
    test_drain_rejoin();
    test_simultaneous();
    test_fill_busy();
    test_reset_mid();
`ifdef STRIDE_CFG_EN
    test_weighted();
    test_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
